// File: rtl/coord_stack_if.sv
// Coordinate stack port bundle: push/pop requests, coordinate data, status.
// COORD_STACK_LEVEL_EN adds the occupancy `level` signal.
interface coord_stack_if #(
    parameter int W     = 4,
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH + 1);

    logic         push;
    logic         pop;
    logic [W-1:0] xIn;
    logic [W-1:0] yIn;
    logic [W-1:0] xOut;
    logic [W-1:0] yOut;
    logic         empty;
    logic         full;
    logic         fail;
`ifdef COORD_STACK_LEVEL_EN
    logic [LW-1:0] level;
`endif

    modport master (
        output push,
        output pop,
        output xIn,
        output yIn,
        input  xOut,
        input  yOut,
        input  empty,
        input  full,
`ifdef COORD_STACK_LEVEL_EN
        input  level,
`endif
        input  fail
    );

    modport slave (
        input  push,
        input  pop,
        input  xIn,
        input  yIn,
        output xOut,
        output yOut,
        output empty,
        output full,
`ifdef COORD_STACK_LEVEL_EN
        output level,
`endif
        output fail
    );
endinterface

// File: rtl/coord_stack.sv
// LIFO of (x, y) coordinate pairs with registered pop data and fail pulse.
// COORD_STACK_LEVEL_EN exposes the occupancy counter on `level`.
module coord_stack #(
    parameter int W     = 4,
    parameter int DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    coord_stack_if.slave   s
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_x_mem [DEPTH];
    logic [W-1:0]  r_y_mem [DEPTH];
    logic [LW-1:0] r_cnt;
    logic [W-1:0]  r_x_out;
    logic [W-1:0]  r_y_out;
    logic          r_fail;

    logic          w_empty;
    logic          w_full;
    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_top_idx;
    logic          w_do_push;
    logic          w_do_pop;
    logic          w_swap;
    logic          w_pass;
    logic          w_err;

    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == LW'(DEPTH));
    assign w_wr_idx  = IW'(r_cnt);
    assign w_top_idx = IW'(r_cnt - 1'b1);

    // Classify the request against the current occupancy
    always_comb begin
        w_do_push = 1'b0;
        w_do_pop  = 1'b0;
        w_swap    = 1'b0;
        w_pass    = 1'b0;
        w_err     = 1'b0;
        unique case ({s.push, s.pop})
            2'b10: begin
                w_do_push = ~w_full;
                w_err     = w_full;
            end
            2'b01: begin
                w_do_pop = ~w_empty;
                w_err    = w_empty;
            end
            2'b11: begin
                w_swap = ~w_empty;
                w_pass = w_empty;
            end
            default: ;
        endcase
    end

    // Entry storage; a swap replaces the top after it has been read out
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_x_mem[w_wr_idx] <= s.xIn;
            r_y_mem[w_wr_idx] <= s.yIn;
        end else if (w_swap) begin
            r_x_mem[w_top_idx] <= s.xIn;
            r_y_mem[w_top_idx] <= s.yIn;
        end
    end

    // Occupancy counter, saturating by construction of the request decode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_do_push) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (w_do_pop) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Pop data register: top entry on pop/swap, input on empty pass-through
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x_out <= '0;
            r_y_out <= '0;
        end else if (w_do_pop || w_swap) begin
            r_x_out <= r_x_mem[w_top_idx];
            r_y_out <= r_y_mem[w_top_idx];
        end else if (w_pass) begin
            r_x_out <= s.xIn;
            r_y_out <= s.yIn;
        end
    end

    // One-cycle fail pulse for every rejected request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fail <= 1'b0;
        end else begin
            r_fail <= w_err;
        end
    end

    assign s.xOut  = r_x_out;
    assign s.yOut  = r_y_out;
    assign s.empty = w_empty;
    assign s.full  = w_full;
    assign s.fail  = r_fail;
`ifdef COORD_STACK_LEVEL_EN
    assign s.level = r_cnt;
`endif
endmodule

// File: tb/tb_coord_stack.sv
// Bench for coord_stack: two instances (W=4/DEPTH=4, W=8/DEPTH=5) driven
// together and compared every cycle against a list-based stack model.
module tb_coord_stack;
    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_on = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    coord_stack_if #(.W(4), .DEPTH(4)) ia ();
    coord_stack_if #(.W(8), .DEPTH(5)) ib ();

    coord_stack #(.W(4), .DEPTH(4)) u_a (
        .clk (clk),
        .rst (rst),
        .s   (ia.slave)
    );

    coord_stack #(.W(8), .DEPTH(5)) u_b (
        .clk (clk),
        .rst (rst),
        .s   (ib.slave)
    );

    // Model: per instance, a list of stored pairs plus last output and fail.
    int mx [2][8];
    int my [2][8];
    int mn [2];
    int mxo [2];
    int myo [2];
    bit mfail [2];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mn[k] = 0;
            mxo[k] = 0;
            myo[k] = 0;
            mfail[k] = 1'b0;
        end
    endtask

    task automatic model_step(input bit p, input bit o, input int x, input int y);
        for (int k = 0; k < 2; k++) begin
            int d;
            int m;
            int xv;
            int yv;
            d = (k == 0) ? 4 : 5;
            m = (k == 0) ? 15 : 255;
            xv = x & m;
            yv = y & m;
            mfail[k] = 1'b0;
            if (p && !o) begin
                if (mn[k] == d) mfail[k] = 1'b1;
                else begin
                    mx[k][mn[k]] = xv;
                    my[k][mn[k]] = yv;
                    mn[k]++;
                end
            end else if (o && !p) begin
                if (mn[k] == 0) mfail[k] = 1'b1;
                else begin
                    mn[k]--;
                    mxo[k] = mx[k][mn[k]];
                    myo[k] = my[k][mn[k]];
                end
            end else if (p && o) begin
                if (mn[k] == 0) begin
                    mxo[k] = xv;
                    myo[k] = yv;
                end else begin
                    mxo[k] = mx[k][mn[k]-1];
                    myo[k] = my[k][mn[k]-1];
                    mx[k][mn[k]-1] = xv;
                    my[k][mn[k]-1] = yv;
                end
            end
        end
    endtask

    task automatic cmp_inst(input string nm, input int k, input logic e,
                            input logic f, input logic fl,
                            input int xo, input int yo);
        int d;
        d = (k == 0) ? 4 : 5;
        chk({nm, ".empty"}, int'(e), int'(mn[k] == 0));
        chk({nm, ".full"}, int'(f), int'(mn[k] == d));
        chk({nm, ".fail"}, int'(fl), int'(mfail[k]));
        chk({nm, ".xOut"}, xo, mxo[k]);
        chk({nm, ".yOut"}, yo, myo[k]);
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_on) begin
            cmp_inst("A", 0, ia.empty, ia.full, ia.fail, int'(ia.xOut), int'(ia.yOut));
            cmp_inst("B", 1, ib.empty, ib.full, ib.fail, int'(ib.xOut), int'(ib.yOut));
`ifdef COORD_STACK_LEVEL_EN
            chk("A.level", int'(ia.level), mn[0]);
            chk("B.level", int'(ib.level), mn[1]);
`endif
        end
    end

    task automatic step(input bit p, input bit o, input int x, input int y);
        ia.push = p;
        ia.pop  = o;
        ia.xIn  = 4'(x);
        ia.yIn  = 4'(y);
        ib.push = p;
        ib.pop  = o;
        ib.xIn  = 8'(x);
        ib.yIn  = 8'(y);
        @(posedge clk);
        model_step(p, o, x, y);
        @(negedge clk);
    endtask

    // Called right after a falling clock edge; completes before the next rise.
    task automatic reset_pulse();
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("rst.A.empty", int'(ia.empty), 1);
        chk("rst.A.fail", int'(ia.fail), 0);
        chk("rst.A.xOut", int'(ia.xOut), 0);
        chk("rst.B.yOut", int'(ib.yOut), 0);
        chk("rst.B.full", int'(ib.full), 0);
        #1 rst = 1'b1;
    endtask

    initial begin
        ia.push = 1'b0; ia.pop = 1'b0; ia.xIn = '0; ia.yIn = '0;
        ib.push = 1'b0; ib.pop = 1'b0; ib.xIn = '0; ib.yIn = '0;
        model_reset();
        #1 rst = 1'b0;
        @(negedge clk);
        chk("init.A.empty", int'(ia.empty), 1);
        chk("init.A.full", int'(ia.full), 0);
        chk("init.A.fail", int'(ia.fail), 0);
        chk("init.B.xOut", int'(ib.xOut), 0);
        rst = 1'b1;
        chk_on = 1'b1;

        // LIFO order
        step(1, 0, 1, 2);
        step(1, 0, 3, 4);
        step(1, 0, 5, 6);
        step(0, 1, 0, 0);
        chk("lifo0.x", int'(ia.xOut), 5);
        chk("lifo0.y", int'(ia.yOut), 6);
        step(0, 1, 0, 0);
        chk("lifo1.x", int'(ia.xOut), 3);
        chk("lifo1.y", int'(ia.yOut), 4);
        step(0, 1, 0, 0);
        chk("lifo2.x", int'(ia.xOut), 1);
        chk("lifo2.y", int'(ia.yOut), 2);
        chk("lifo.empty", int'(ia.empty), 1);

        // Underflow holds the last popped pair
        step(0, 1, 0, 0);
        chk("under.fail", int'(ia.fail), 1);
        chk("under.x", int'(ia.xOut), 1);
        chk("under.y", int'(ia.yOut), 2);
        step(0, 0, 0, 0);
        chk("under.clear", int'(ia.fail), 0);

        // Overflow on the 4-deep instance
        for (int i = 1; i <= 4; i++) step(1, 0, i, i);
        chk("ovf.full", int'(ia.full), 1);
        step(1, 0, 9, 9);
        chk("ovf.fail", int'(ia.fail), 1);
        chk("ovf.B.nofail", int'(ib.fail), 0);
        step(0, 1, 0, 0);
        chk("ovf.fail.clr", int'(ia.fail), 0);
        chk("ovf.pop0", int'(ia.xOut), 4);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        chk("ovf.pop3", int'(ia.xOut), 1);
        chk("ovf.empty", int'(ia.empty), 1);

        // Reset between edges with entries present
        for (int i = 0; i < 3; i++) step(1, 0, i + 2, i + 7);
        reset_pulse();
        step(0, 1, 0, 0);
        chk("rst.pop.fail", int'(ia.fail), 1);

        // Simultaneous push and pop
        step(1, 0, 1, 2);
        step(1, 0, 3, 4);
        step(1, 1, 7, 8);
        chk("swap.x", int'(ia.xOut), 3);
        chk("swap.y", int'(ia.yOut), 4);
        chk("swap.notempty", int'(ia.empty), 0);
        step(0, 1, 0, 0);
        chk("swap.next.x", int'(ia.xOut), 7);
        chk("swap.next.y", int'(ia.yOut), 8);
        step(0, 1, 0, 0);
        step(1, 1, 10, 11);
        chk("pass.x", int'(ia.xOut), 10);
        chk("pass.y", int'(ia.yOut), 11);
        chk("pass.empty", int'(ia.empty), 1);
        chk("pass.fail", int'(ia.fail), 0);

        // Wide, non-power-of-two instance: fill, check full, drain
        step(1, 0, 8'h80, 8'hFF);
        for (int i = 1; i < 5; i++) step(1, 0, i, i + 16);
        chk("B.full5", int'(ib.full), 1);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        chk("B.bit7.x", int'(ib.xOut), 8'h80);
        chk("B.bit7.y", int'(ib.yOut), 8'hFF);
        chk("B.drained", int'(ib.empty), 1);

        // Randomized traffic with fill/drain bias and occasional reset
        for (int c = 0; c < 3000; c++) begin
            int bias;
            bit p;
            bit o;
            bias = ((c / 40) % 2 == 0) ? 70 : 30;
            p = ($urandom_range(0, 99) < bias);
            o = ($urandom_range(0, 99) < (100 - bias));
            step(p, o, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            if ($urandom_range(0, 249) == 0) reset_pulse();
        end

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
